rs_issue_sched: RTL
===================

// Module: rs_issue_sched
// PURPOSE
// - Issue scheduler for the reservation station. Each cycle it picks at most one RS entry whose operands are ready,
//   whose functional unit (FU) is free, and whose writeback slot on the single CDB is free.
// - Clears the chosen entry, sends a registered issue request to the FU stage, and tracks FU occupancy.
// - Sits between the RS table and the execute stage.
// - Reserves CDB slots ahead of time so two FUs never complete in the same cycle.
// PARAMETERS
// RS_SZ     5  number of RS entries scheduled (matches `RS_SZ)
// ALU_LAT   1  cycles from issue to CDB broadcast, ALU
// LD_LAT    2  cycles from issue to CDB broadcast, LD
// MULT_LAT  4  cycles from issue to CDB broadcast, FP1/FP2; the multiplier is not pipelined
// PORTS
// clock          in   1              system clock
// reset          in   1              synchronous, active-high
// squash         in   1              flush of in-flight work (branch mispredict)
// entry_busy     in   RS_SZ          RS entry holds an instruction
// entry_ready    in   RS_SZ          both source tags of the entry are ready
// entry_fu       in   RS_SZ x FU     FU class of each entry (ALU/LD/ST/FP1/FP2)
// entry_clear    out  RS_SZ          one-hot, combinational: the RS clears this entry at the next edge
// issue_valid    out  1              registered issue request to execute
// issue_idx      out  $clog2(RS_SZ)  RS index issued
// issue_fu       out  FU             FU class issued
// fu_busy        out  5              per-FU occupied flag, ordered {FP2,FP1,ST,LD,ALU}
// cdb_valid      out  1              a reserved completion broadcasts this cycle
// cdb_fu         out  FU             FU that owns the current CDB slot
// BEHAVIOUR
// - Reset: all outputs 0; rr_ptr=0; reservation shift register 0; all FU counters 0.
// - Eligibility of entry i requires all of:
//   - entry_busy[i] & entry_ready[i] & !squash;
//   - fu_busy[entry_fu[i]]==0;
//   - for non-ST entries, reservation bit res[lat(fu)-1]==0.
//   - ST never writes the CDB and takes no reservation.
// - Selection:
//   - Round-robin over eligible entries, starting at rr_ptr and wrapping modulo RS_SZ.
//   - At most one grant per cycle; entry_clear[g]=1 in the same cycle.
// - At the edge after a grant g:
//   - issue_valid=1, issue_idx=g, issue_fu=entry_fu[g];
//   - rr_ptr=(g+1)%RS_SZ; with no grant, rr_ptr holds and issue_valid=0.
// - Reservations:
//   - res[MULT_LAT-1:0] shifts toward bit 0 every cycle.
//   - A grant with latency L sets res[L-1], and owner[L-1]=fu, after the shift.
//   - cdb_valid=res[0] and cdb_fu=owner[0], both registered.
// - FU occupancy:
//   - ALU/LD/ST are pipelined: fu_busy is never set for them.
//   - FP1/FP2: issuing loads that unit's counter with MULT_LAT; fu_busy=(cnt!=0); the counter decrements each cycle.
//   - A unit may be re-issued the cycle its counter reads 1, since it becomes 0 at that edge.
// - FP placement: the RS places FP ops in either FP1 or FP2; the scheduler treats the two as independent units.
// - Simultaneous events: an entry completing its reservation at res[0] while a new grant targets slot 0 cannot happen,
//   because slot L-1>=0 is checked after the shift, using the shifted value.
// - squash:
//   - entry_clear=0 that cycle.
//   - Next edge: res, owner, FP counters and issue_valid cleared; cdb_valid=0; rr_ptr holds.
// - reset overrides squash. Reset mid-operation discards all reservations, with no CDB pulse afterwards.
// - RS_SZ not a power of two: the rr_ptr wrap is explicit compare, not a truncated add.
// STRUCTURE
// - Shared package (sys_defs): FU enum (existing), lat_of(FU) function, FU_COUNT=5 constant.
// - Sub-module rr_arbiter #(N): request vector plus pointer in, one-hot grant plus index out.
//   Purely combinational, double-width mask method.
// - Top level holds rr_ptr, the reservation shift register plus owner array, the FP counters, and output registers.
// TESTING
// - Single ALU entry 0 ready at cycle 0 -> entry_clear=00001 at c0; issue_valid, idx=0 at c1; cdb_valid, cdb_fu=ALU at c1.
// - Entries 1,3 both ALU-ready, rr_ptr=2 -> grant 3 first, then 1 next cycle; rr_ptr=4, then 2.
// - MULT issued on FP1 at c0, LD ready at c2 (slot LD_LAT-1 overlaps MULT reservation at res[1]) ->
//   LD delayed to c3; CDB pulses at c4 (FP1) and c5 (LD), never together.
// - Two MULTs ready at c0 on FP1 -> second waits until fu_busy[FP1] drops; issues at c4; FP2 op concurrent at c1 allowed.
// - ST ready while all CDB slots are reserved -> ST issues immediately; no cdb_valid is generated for it.
// - squash at c2 with MULT in flight -> no cdb_valid at c4; fu_busy=0 at c3; reset at c1 gives all outputs 0 at c2.

Source files
------------

// File: rtl/rs_issue_sched_pkg.sv
// Shared scheduler definitions: FU classes, latencies and derived widths.
package rs_issue_sched_pkg;

  localparam int unsigned RS_SZ    = 5;
  localparam int unsigned ALU_LAT  = 1;
  localparam int unsigned LD_LAT   = 2;
  localparam int unsigned MULT_LAT = 4;
  localparam int unsigned FU_COUNT = 5;
  localparam int unsigned FU_W     = 3;
  localparam int unsigned IDX_W    = $clog2(RS_SZ);
  localparam int unsigned LAT_W    = $clog2(MULT_LAT + 1);
  localparam int unsigned SLOT_W   = $clog2(MULT_LAT);

  // Encoding doubles as the bit position in the fu_busy vector.
  typedef enum logic [FU_W-1:0] {
    FU_ALU = 3'd0,
    FU_LD  = 3'd1,
    FU_ST  = 3'd2,
    FU_FP1 = 3'd3,
    FU_FP2 = 3'd4
  } fu_e;

  // Issue-to-CDB latency; zero means the unit never writes the CDB.
  function automatic logic [LAT_W-1:0] lat_of(input fu_e fu);
    case (fu)
      FU_ALU:         lat_of = LAT_W'(ALU_LAT);
      FU_LD:          lat_of = LAT_W'(LD_LAT);
      FU_FP1, FU_FP2: lat_of = LAT_W'(MULT_LAT);
      default:        lat_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/rs_issue_sched_rr_arb.sv
// Combinational round-robin arbiter (double-width mask method).
//   i_req   : request vector
//   i_ptr   : highest-priority index (must be < N)
//   o_grant : one-hot grant
//   o_idx   : index of the granted request
//   o_valid : any request granted
module rs_issue_sched_rr_arb #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_cand;
  logic           w_found;
  int unsigned    w_sel;

  // Lowest set bit at or above the pointer in the doubled vector wraps naturally.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_mask  = '0;
    w_found = 1'b0;
    w_sel   = 0;
    o_grant = '0;
    for (int unsigned j = 0; j < 2*N; j++) begin
      w_mask[j] = (j >= 32'(i_ptr));
    end
    w_cand = w_dbl & w_mask;
    for (int unsigned j = 0; j < 2*N; j++) begin
      if (!w_found && w_cand[j]) begin
        w_found = 1'b1;
        w_sel   = (j < N) ? j : (j - N);
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      o_grant[k] = w_found && (w_sel == k);
    end
    o_idx   = IW'(w_sel);
    o_valid = w_found;
  end

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: one issue per cycle, FP occupancy
// tracking, and CDB slot reservation so completions never collide.
//   i_clock, i_reset   : clock, synchronous active-high reset
//   i_squash           : flush in-flight work
//   i_entry_busy/ready : per-entry valid and operands-ready
//   i_entry_fu         : packed FU class per entry (FU_W bits each)
//   o_entry_clear      : combinational one-hot clear of the granted entry
//   o_issue_*          : registered issue request to execute
//   o_fu_busy          : per-FU occupied, {FP2,FP1,ST,LD,ALU}
//   o_cdb_valid/fu     : reserved completion broadcasting this cycle
module rs_issue_sched
  import rs_issue_sched_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_squash,
  input  logic [RS_SZ-1:0]      i_entry_busy,
  input  logic [RS_SZ-1:0]      i_entry_ready,
  input  logic [RS_SZ*FU_W-1:0] i_entry_fu,
  output logic [RS_SZ-1:0]      o_entry_clear,
  output logic                  o_issue_valid,
  output logic [IDX_W-1:0]      o_issue_idx,
  output logic [FU_W-1:0]       o_issue_fu,
  output logic [FU_COUNT-1:0]   o_fu_busy,
  output logic                  o_cdb_valid,
  output logic [FU_W-1:0]       o_cdb_fu
);

  logic [IDX_W-1:0]    r_rr_ptr;
  logic [MULT_LAT-1:0] r_res;
  fu_e                 r_owner [MULT_LAT];
  logic [LAT_W-1:0]    r_fp1_cnt;
  logic [LAT_W-1:0]    r_fp2_cnt;
  logic                r_issue_valid;
  logic [IDX_W-1:0]    r_issue_idx;
  fu_e                 r_issue_fu;
  logic [FU_COUNT-1:0] r_fu_busy;

  fu_e                 w_fu  [RS_SZ];
  logic [LAT_W-1:0]    w_lat [RS_SZ];
  logic [RS_SZ-1:0]    w_fu_free;
  logic [RS_SZ-1:0]    w_slot_free;
  logic [RS_SZ-1:0]    w_req;
  logic [MULT_LAT-1:0] w_res_sh;
  logic [RS_SZ-1:0]    w_grant;
  logic [IDX_W-1:0]    w_gidx;
  logic                w_gvalid;
  fu_e                 w_gfu;
  logic [LAT_W-1:0]    w_glat;
  logic [MULT_LAT-1:0] w_res_nxt;
  fu_e                 w_owner_nxt [MULT_LAT];
  logic [LAT_W-1:0]    w_fp1_nxt;
  logic [LAT_W-1:0]    w_fp2_nxt;
  logic [IDX_W-1:0]    w_rr_nxt;

  // Slots are judged on the post-shift view, i.e. where a new grant would land.
  assign w_res_sh = {1'b0, r_res[MULT_LAT-1:1]};

  // Per-entry eligibility. An FP unit is free once its counter is at most 1.
  always_comb begin
    w_fu_free   = '0;
    w_slot_free = '0;
    w_req       = '0;
    for (int i = 0; i < RS_SZ; i++) begin
      w_fu[i]  = fu_e'(i_entry_fu[i*FU_W +: FU_W]);
      w_lat[i] = lat_of(w_fu[i]);
      case (w_fu[i])
        FU_ALU, FU_LD, FU_ST: w_fu_free[i] = 1'b1;
        FU_FP1:               w_fu_free[i] = (r_fp1_cnt <= LAT_W'(1));
        FU_FP2:               w_fu_free[i] = (r_fp2_cnt <= LAT_W'(1));
        default:              w_fu_free[i] = 1'b0;
      endcase
      w_slot_free[i] = 1'b1;
      if (w_lat[i] != '0) begin
        w_slot_free[i] = !w_res_sh[SLOT_W'(w_lat[i] - LAT_W'(1))];
      end
      w_req[i] = i_entry_busy[i] & i_entry_ready[i] & !i_squash & !i_reset
               & w_fu_free[i] & w_slot_free[i];
    end
  end

  rs_issue_sched_rr_arb #(
    .N  (RS_SZ),
    .IW (IDX_W)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  // Next-state for reservations, FP counters and pointer.
  always_comb begin
    w_gfu = FU_ALU;
    for (int i = 0; i < RS_SZ; i++) begin
      if (w_grant[i]) w_gfu = w_fu[i];
    end
    w_glat    = lat_of(w_gfu);
    w_res_nxt = w_res_sh;
    for (int k = 0; k < MULT_LAT; k++) begin
      w_owner_nxt[k] = (k < MULT_LAT - 1) ? r_owner[k+1] : FU_ALU;
    end
    if (w_gvalid && (w_glat != '0)) begin
      w_res_nxt[SLOT_W'(w_glat - LAT_W'(1))]   = 1'b1;
      w_owner_nxt[SLOT_W'(w_glat - LAT_W'(1))] = w_gfu;
    end
    w_fp1_nxt = (r_fp1_cnt != '0) ? r_fp1_cnt - LAT_W'(1) : '0;
    w_fp2_nxt = (r_fp2_cnt != '0) ? r_fp2_cnt - LAT_W'(1) : '0;
    if (w_gvalid && (w_gfu == FU_FP1)) w_fp1_nxt = LAT_W'(MULT_LAT);
    if (w_gvalid && (w_gfu == FU_FP2)) w_fp2_nxt = LAT_W'(MULT_LAT);
    // Explicit wrap: RS_SZ is not a power of two.
    w_rr_nxt = (w_gidx == IDX_W'(RS_SZ - 1)) ? '0 : w_gidx + IDX_W'(1);
  end

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rr_ptr      <= '0;
      r_res         <= '0;
      r_fp1_cnt     <= '0;
      r_fp2_cnt     <= '0;
      r_issue_valid <= 1'b0;
      r_issue_idx   <= '0;
      r_issue_fu    <= FU_ALU;
      r_fu_busy     <= '0;
      for (int k = 0; k < MULT_LAT; k++) r_owner[k] <= FU_ALU;
    end else if (i_squash) begin
      r_res         <= '0;
      r_fp1_cnt     <= '0;
      r_fp2_cnt     <= '0;
      r_issue_valid <= 1'b0;
      r_fu_busy     <= '0;
      for (int k = 0; k < MULT_LAT; k++) r_owner[k] <= FU_ALU;
    end else begin
      r_res         <= w_res_nxt;
      r_fp1_cnt     <= w_fp1_nxt;
      r_fp2_cnt     <= w_fp2_nxt;
      r_issue_valid <= w_gvalid;
      r_fu_busy     <= {w_fp2_nxt != '0, w_fp1_nxt != '0, 3'b000};
      for (int k = 0; k < MULT_LAT; k++) r_owner[k] <= w_owner_nxt[k];
      if (w_gvalid) begin
        r_rr_ptr    <= w_rr_nxt;
        r_issue_idx <= w_gidx;
        r_issue_fu  <= w_gfu;
      end
    end
  end

  assign o_entry_clear = w_grant;
  assign o_issue_valid = r_issue_valid;
  assign o_issue_idx   = r_issue_idx;
  assign o_issue_fu    = r_issue_fu;
  assign o_fu_busy     = r_fu_busy;
  assign o_cdb_valid   = r_res[0];
  assign o_cdb_fu      = r_owner[0];

endmodule
